// File: rtl/pulpino_xfer_ctrl.sv
// Host-side transfer sequencer for the USB <-> PULPino GPIO word channel.
// Loads one command word via do_read, tracks the done toggles and returns the reply.
module pulpino_xfer_ctrl #(
    parameter int LOAD_HOLD      = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic        cmd_expect_rsp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [31:0] read_data,
    output logic        do_read,
    input  logic        data_in_done,
    input  logic        data_out_done,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        timeout_sticky,
    input  logic        clr_err,
    output logic [15:0] xfer_count
);
    // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
    // a response transfers on an edge where rsp_valid && rsp_ready, and
    // rsp_valid/rsp_data/rsp_timeout hold steady until that edge.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RELEASE  = 3'd2,
        WAIT_IN  = 3'd3,
        WAIT_OUT = 3'd4,
        RESP     = 3'd5
    } state_e;

    localparam int HW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LOAD_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          do_read_q, do_read_d;
    logic          exp_q, exp_d;
    logic          in_ref_q, in_ref_d;
    logic          out_ref_q, out_ref_d;
    logic          out_seen_q, out_seen_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          sticky_q, sticky_d;
    logic [15:0]   xfer_count_q, xfer_count_d;
    logic          tracking, out_hit, tmo_hit;

    always_comb begin
        state_d       = state_q;
        read_data_d   = read_data_q;
        do_read_d     = do_read_q;
        exp_d         = exp_q;
        in_ref_d      = in_ref_q;
        out_ref_d     = out_ref_q;
        out_seen_d    = out_seen_q;
        hold_cnt_d    = hold_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        sticky_d      = sticky_q;
        xfer_count_d  = xfer_count_q;
        tmo_hit       = 1'b0;

        tracking = (state_q == LOAD) || (state_q == RELEASE) ||
                   (state_q == WAIT_IN) || (state_q == WAIT_OUT);
        out_hit  = tracking && (data_out_done != out_ref_q) && !out_seen_q;

        if (clr_err) sticky_d = 1'b0;

        if (tracking && (tmo_cnt_q != TMO_LAST)) tmo_cnt_d = tmo_cnt_q + 1'b1;
        // The first reply toggle is latched in any active state so an early reply survives.
        if (out_hit) begin
            out_seen_d = 1'b1;
            rsp_data_d = write_data;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    read_data_d = cmd_data;
                    exp_d       = cmd_expect_rsp;
                    in_ref_d    = data_in_done;
                    out_ref_d   = data_out_done;
                    out_seen_d  = 1'b0;
                    tmo_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    do_read_d   = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    do_read_d = 1'b0;
                    state_d   = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE: state_d = WAIT_IN;
            WAIT_IN: begin
                if (data_in_done != in_ref_q) begin
                    if (exp_q) begin
                        state_d = WAIT_OUT;
                    end else begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                end
            end
            WAIT_OUT: begin
                if (out_seen_q || out_hit) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!rsp_timeout_q) xfer_count_d = xfer_count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_data_d    = '0;
            sticky_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= IDLE;
            read_data_q   <= '0;
            do_read_q     <= 1'b0;
            exp_q         <= 1'b0;
            in_ref_q      <= 1'b0;
            out_ref_q     <= 1'b0;
            out_seen_q    <= 1'b0;
            hold_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= 1'b0;
            xfer_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            read_data_q   <= read_data_d;
            do_read_q     <= do_read_d;
            exp_q         <= exp_d;
            in_ref_q      <= in_ref_d;
            out_ref_q     <= out_ref_d;
            out_seen_q    <= out_seen_d;
            hold_cnt_q    <= hold_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            sticky_q      <= sticky_d;
            xfer_count_q  <= xfer_count_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign read_data      = read_data_q;
    assign do_read        = do_read_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign timeout_sticky = sticky_q;
    assign xfer_count     = xfer_count_q;
endmodule

// File: tb/tb_pulpino_xfer_ctrl.sv
// Directed bench for pulpino_xfer_ctrl: expected responses are queued when a
// command is issued and compared when the response handshake happens.
module tb_pulpino_xfer_ctrl;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = '0;
    logic        cmd_expect_rsp = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [31:0] read_data;
    logic        do_read;
    logic        data_in_done = 1'b0;
    logic        data_out_done = 1'b0;
    logic [31:0] write_data = '0;
    logic        busy;
    logic        timeout_sticky;
    logic        clr_err = 1'b0;
    logic [15:0] xfer_count;

    logic [32:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    pulpino_xfer_ctrl #(.LOAD_HOLD(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_expect_rsp(cmd_expect_rsp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .read_data(read_data), .do_read(do_read),
        .data_in_done(data_in_done), .data_out_done(data_out_done),
        .write_data(write_data),
        .busy(busy), .timeout_sticky(timeout_sticky), .clr_err(clr_err),
        .xfer_count(xfer_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns one cycle after the acceptance edge (first LOAD cycle).
    task automatic send_cmd(input logic [31:0] d, input logic e);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data = d;
        cmd_expect_rsp = e;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic take_rsp(input string tag);
        logic [32:0] e;
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({tag, "_rsp_data"}, rsp_data, e[31:0]);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(e[32]));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_do_read", 32'(do_read), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sticky", 32'(timeout_sticky), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        reset_i = 1'b0;
        step();

        // 1: no reply expected, in-toggle 5 cycles into WAIT_IN
        exp_q.push_back({1'b0, 32'h0});
        send_cmd(32'hDEADBEEF, 1'b0);
        check("t1_do_read_c1", 32'(do_read), 32'd1);
        check("t1_read_data", read_data, 32'hDEADBEEF);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        check("t1_do_read_c2", 32'(do_read), 32'd1);
        step();
        check("t1_do_read_c3", 32'(do_read), 32'd0);
        step();
        check("t1_do_read_waitin", 32'(do_read), 32'd0);
        repeat (5) step();
        check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
        data_in_done = ~data_in_done;
        step();
        check("t1_rsp_rise", 32'(rsp_valid), 32'd1);
        take_rsp("t1");
        check("t1_xfer_count", 32'(xfer_count), 32'd1);
        check("t1_read_data_hold", read_data, 32'hDEADBEEF);

        // 2: reply after input done
        exp_q.push_back({1'b0, 32'h12345678});
        send_cmd(32'hA5A50001, 1'b1);
        repeat (3) step();
        data_in_done = ~data_in_done;
        step();
        check("t2_wait_out_no_rsp", 32'(rsp_valid), 32'd0);
        write_data = 32'h12345678;
        data_out_done = ~data_out_done;
        step();
        check("t2_rsp_rise", 32'(rsp_valid), 32'd1);
        write_data = 32'h0;
        data_out_done = ~data_out_done;
        step();
        take_rsp("t2");
        check("t2_xfer_count", 32'(xfer_count), 32'd2);

        // 3: reply arrives during LOAD, before input done; later toggle ignored
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        send_cmd(32'h00000003, 1'b1);
        write_data = 32'hCAFEF00D;
        data_out_done = ~data_out_done;
        step();
        write_data = 32'h0BAD0BAD;
        data_out_done = ~data_out_done;
        repeat (2) step();
        check("t3_no_rsp_before_in", 32'(rsp_valid), 32'd0);
        data_in_done = ~data_in_done;
        step();
        take_rsp("t3");
        check("t3_xfer_count", 32'(xfer_count), 32'd3);

        // 4: timeout with clr_err held over the timeout edge (set wins)
        exp_q.push_back({1'b1, 32'h0});
        send_cmd(32'h11111111, 1'b1);
        clr_err = 1'b1;
        repeat (15) step();
        check("t4_no_rsp_before_tmo", 32'(rsp_valid), 32'd0);
        step();
        clr_err = 1'b0;
        check("t4_tmo_rsp_rise", 32'(rsp_valid), 32'd1);
        check("t4_sticky_set", 32'(timeout_sticky), 32'd1);
        take_rsp("t4");
        check("t4_xfer_unchanged", 32'(xfer_count), 32'd3);
        check("t4_sticky_held", 32'(timeout_sticky), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_sticky_cleared", 32'(timeout_sticky), 32'd0);

        // 5: response back-pressure with a second command pending
        exp_q.push_back({1'b0, 32'h0});
        send_cmd(32'h0BADF00D, 1'b0);
        repeat (3) step();
        data_in_done = ~data_in_done;
        step();
        cmd_valid = 1'b1;
        cmd_data = 32'h55AA55AA;
        cmd_expect_rsp = 1'b0;
        write_data = 32'hFFFFFFFF;
        data_out_done = ~data_out_done;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t5_hold_rsp_data", rsp_data, 32'h0);
            check("t5_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            step();
        end
        check("t5_read_data_hold", read_data, 32'h0BADF00D);
        take_rsp("t5a");
        exp_q.push_back({1'b0, 32'h0});
        send_cmd(32'h55AA55AA, 1'b0);
        check("t5_second_read_data", read_data, 32'h55AA55AA);
        check("t5_second_do_read", 32'(do_read), 32'd1);
        repeat (3) step();
        data_in_done = ~data_in_done;
        step();
        take_rsp("t5b");
        check("t5_xfer_count", 32'(xfer_count), 32'd5);

        // 6: reset during WAIT_OUT aborts with no response
        send_cmd(32'h66666666, 1'b1);
        repeat (3) step();
        data_in_done = ~data_in_done;
        step();
        check("t6_busy_wait_out", 32'(busy), 32'd1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("t6_do_read", 32'(do_read), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_xfer_count", 32'(xfer_count), 32'd0);
        write_data = 32'h77777777;
        data_out_done = ~data_out_done;
        repeat (3) step();
        check("t6_no_late_rsp", 32'(rsp_valid), 32'd0);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pulpino_xfer_ctrl.md
# pulpino_xfer_ctrl

Host-side transfer sequencer for the USB↔PULPino GPIO word channel. It accepts one 32-bit command word at a time from the USB register interface and drives the channel's `read_data`/`do_read` load strobe. It then tracks the channel's `data_in_done` and `data_out_done` toggles to detect completion, captures the PULPino reply from `write_data`, and returns it with a timeout flag. It sits between the USB register file and the GPIO comm block and is the only driver of `do_read`.

## Interface
- `LOAD_HOLD`, 2: cycles `do_read` is held high per load (≥1).
- `TIMEOUT_CYCLES`, 1000000: cycles from acceptance before a pending transfer is aborted (≥4).
- `clk`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command word available.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_data`  in  32  word to send to PULPino.
- `cmd_expect_rsp`  in  1  1 = wait for a PULPino reply word after delivery.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host consumes response.
- `rsp_data`  out  32  captured reply, or 0.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `read_data`  out  32  word presented to the comm block.
- `do_read`  out  1  load strobe to the comm block.
- `data_in_done`  in  1  toggles when PULPino has consumed a full input word.
- `data_out_done`  in  1  toggles when PULPino has produced a full output word.
- `write_data`  in  32  PULPino output word from the comm block.
- `busy`  out  1  state ≠ IDLE.
- `timeout_sticky`  out  1  set on any timeout, cleared by `clr_err` or reset.
- `clr_err`  in  1  clears `timeout_sticky`.
- `xfer_count`  out  16  completed (non-timeout) transfers, wraps at 0xFFFF→0.

## Operation
- States: IDLE, LOAD, RELEASE, WAIT_IN, WAIT_OUT, RESP.
- IDLE: `cmd_ready=1`. Accept on `cmd_valid&cmd_ready`, then:
  - latch `cmd_data` into `read_data` and `cmd_expect_rsp` into `exp`;
  - snapshot `in_ref<=data_in_done` and `out_ref<=data_out_done`;
  - clear `out_seen` and the timeout counter;
  - go to LOAD.
- LOAD: `do_read=1` for exactly `LOAD_HOLD` cycles, then RELEASE.
- RELEASE: `do_read=0` for one cycle, guaranteeing the comm block re-arms. Then WAIT_IN.
- WAIT_IN: on `data_in_done!=in_ref`, go to WAIT_OUT if `exp`, otherwise go to RESP with `rsp_data=0`.
- Out-toggle tracking runs in LOAD, RELEASE, WAIT_IN and WAIT_OUT. The first cycle with `data_out_done!=out_ref` and `out_seen=0` sets `out_seen` and captures `write_data` into `rsp_data` the same cycle. A reply that arrives before input-done is therefore not lost. Later toggles in the same transfer are ignored.
- WAIT_OUT: go to RESP once `out_seen=1`, including the case where it was already set on entry.
- Timeout counter increments every non-IDLE, non-RESP cycle. On reaching `TIMEOUT_CYCLES-1` in WAIT_IN or WAIT_OUT:
  - go to RESP with `rsp_timeout=1` and `rsp_data=0`;
  - set `timeout_sticky`.
  - A completion and a timeout in the same cycle: completion wins.
- RESP: `rsp_valid=1` and outputs stable until `rsp_ready`. On the handshake:
  - increment `xfer_count` if not a timeout;
  - go to IDLE.
  - `cmd_ready` stays 0 until the state is IDLE.
- `clr_err` and a timeout in the same cycle: the set wins.
- Reset mid-transfer aborts immediately. There is no response and `xfer_count` is unchanged by the abort (reset zeroes it).

## Timing
- Reset values:
  - state IDLE;
  - `cmd_ready=1`, `do_read=0`, `read_data=0`;
  - `rsp_valid=0`, `rsp_data=0`, `rsp_timeout=0`;
  - `busy=0`, `timeout_sticky=0`, `xfer_count=0`.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from state.
- Acceptance at edge T:
  - `do_read` and `read_data` are valid from T+1;
  - `do_read` is high for cycles T+1..T+`LOAD_HOLD`;
  - `do_read` is low at T+`LOAD_HOLD`+1;
  - WAIT_IN starts at T+`LOAD_HOLD`+2.
- Toggle seen at edge E: the next state takes effect at E+1, and `rsp_valid` rises at E+1 when entering RESP.
- Minimum command-to-response latency is `LOAD_HOLD`+3 cycles. One response handshake per cycle at most; back-to-back commands restart at IDLE.
- `read_data` holds its value after the transfer until the next acceptance.

## Test plan
- `LOAD_HOLD=2`, `cmd_data=0xDEADBEEF`, `exp=0`; toggle `data_in_done` 5 cycles after WAIT_IN → `do_read` high exactly 2 cycles, then `rsp_valid=1`, `rsp_data=0`, `rsp_timeout=0`, `xfer_count=1`.
- `exp=1`; `data_in_done` toggles, then `data_out_done` toggles with `write_data=0x12345678` → `rsp_data=0x12345678`.
- `exp=1`; `data_out_done` toggles with `write_data=0xCAFEF00D` during LOAD, before `data_in_done` → reply retained; RESP entered one cycle after the in-toggle.
- `TIMEOUT_CYCLES=16`, no toggles → `rsp_timeout=1`, `rsp_data=0`, `timeout_sticky=1`, `xfer_count` unchanged; `clr_err` pulse → sticky is 0.
- `rsp_ready` held low for 10 cycles with a second `cmd_valid` pending → `rsp_*` stable, `cmd_ready=0`; after the handshake the second command is accepted at IDLE.
- `reset_i` asserted during WAIT_OUT → next cycle `do_read=0`, `rsp_valid=0`, `busy=0`, `xfer_count=0`.
